elevator_call_latch: RTL and testbench
======================================

Name: elevator_call_latch

Overview:
- Request-side front end for the elevator FSM. It turns raw board inputs into latched floor calls and tells the FSM where to go next.
- Inputs are cabin buttons (KEY, active-low) and hall-call switches (SW[3:0]). They are synchronised and edge-detected, then held in pending bitmaps until the FSM reports service at that floor.
- A SCAN policy (keep direction while calls remain ahead) selects the next target. This block is the producer half of the request/service interface the elevator FSM consumes.

Parameters:
- N_FLOORS, 4, number of floors; fixed at 4 for this revision.
- FLOOR_W, 2, floor index width; floor 1 is index 0.
- SYNC_STAGES, 2, flip-flop stages per input synchroniser, minimum 2.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset, driven from SW[17] at top level.
- cab_key_n  in  4  cabin buttons, active-low, asynchronous to CLOCK_50.
- hall_sw  in  4  hall-call switches, active-high, asynchronous.
- cur_floor  in  FLOOR_W  current cabin floor, from the FSM.
- svc_pulse  in  1  one-cycle pulse from the FSM when the door opens at cur_floor.
- req_valid  out  1  at least one call is pending.
- req_floor  out  FLOOR_W  selected target floor.
- req_dir  out  1  scan direction: 1 = up, 0 = down.
- pend_cab  out  4  pending cabin calls.
- pend_hall  out  4  pending hall calls.
- pend_any  out  4  pend_cab | pend_hall; drives LEDR.

Behaviour:
- Reset values: pend_cab = 0, pend_hall = 0, req_valid = 0, req_floor = 0, req_dir = 1 (up). Synchroniser and edge registers load their idle levels: cab 1, hall 0.
- Reset mid-operation drops every pending call. The first edge check after reset only looks at the post-reset idle level, so a key already held through reset does not register.
- Input path: SYNC_STAGES flip-flops, then one edge register per bit.
  - Cabin call: falling edge on the synchronised key.
  - Hall call: rising edge on the synchronised switch.
  - A held input produces exactly one call.
- Latency: input change to pend_* bit set is SYNC_STAGES+1 cycles (3 at default).
- Pending update, per floor f, each cycle:
  - Set when an edge arrives for f.
  - Clear when svc_pulse=1 and cur_floor=f; clears both the cabin and hall bits for f.
  - Clear has priority over set for the same f in the same cycle. The call counts as served by the opening door.
  - Setting a bit that is already set is a no-op. Simultaneous edges on several floors all latch in the same cycle.
- Target selection is registered: req_* reflect the pending state of the previous cycle, i.e. one cycle after pend_* change.
  - pend_any == 0: req_valid = 0; req_floor holds; req_dir holds.
  - A call is pending at cur_floor and svc_pulse = 0: req_floor = cur_floor; direction unchanged.
  - req_dir = 1 with any pending floor above cur_floor: req_floor = lowest pending floor above.
  - req_dir = 1 with none above: req_dir becomes 0; req_floor = highest pending floor below.
  - req_dir = 0: mirror image of the up rules.
- Boundaries:
  - At floor index 3 no floor is above, so req_dir flips to 0.
  - At floor index 0 no floor is below, so req_dir flips to 1.
- svc_pulse with no call pending at cur_floor is harmless; nothing changes.
- cur_floor is sampled only through the registered selection path. No combinational path exists from any input to any output.

Decomposition:
- Shared package elevator_pkg:
  - constants N_FLOORS = 4, FLOOR_W = 2;
  - direction encodings DIR_UP = 1'b1, DIR_DN = 1'b0;
  - floor index constants F1..F4 = 0..3.
  - The elevator FSM imports the same package.
- One sub-module, elevator_in_sync: a parameterised-width synchroniser plus edge detector with an edge-polarity parameter. It is instantiated twice, once for cabin and once for hall.

Test Plan:
- Reset, then hold cab_key_n[2] = 0 for 20 cycles: pend_cab = 4'b0100 exactly 3 cycles after the press, never set again while held. req_floor = 2, req_dir = 1, req_valid = 1 on the following cycle.
- cur_floor = 0; hall_sw[0] and hall_sw[3] rise together: pend_hall = 4'b1001. First target is req_floor = 0 (at floor). After svc_pulse at floor 0, req_floor = 3, req_dir = 1.
- cur_floor = 1, req_dir = 1; pend_any = 4'b0101: req_floor = 2. After svc_pulse at floor 2 with cur_floor = 2, req_dir = 0 and req_floor = 0.
- Same-cycle conflict: a cabin edge for floor 1 arrives in the same cycle as svc_pulse with cur_floor = 1. pend_cab[1] stays 0 and req_valid falls if nothing else is pending.
- All four hall switches rise at once from cur_floor = 0: pend_hall = 4'b1111. Stepping cur_floor 0..3 with a svc_pulse at each floor yields targets 0,1,2,3 in order with req_dir = 1 throughout. After the last service, req_valid = 0.
- Assert rst for 1 cycle with pend_any = 4'b1010: next cycle all pending bits = 0, req_valid = 0, req_dir = 1. A key still held low through reset produces no call.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared floor/direction definitions for the elevator request front end and FSM.
// Floor 1 is index 0; direction bit is 1 for up.
package elevator_pkg;

   localparam int N_FLOORS = 4;
   localparam int FLOOR_W  = 2;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef logic [FLOOR_W-1:0]  floor_t;
   typedef logic [N_FLOORS-1:0] fmask_t;

   localparam floor_t F1 = 2'd0;
   localparam floor_t F2 = 2'd1;
   localparam floor_t F3 = 2'd2;
   localparam floor_t F4 = 2'd3;

   function automatic fmask_t floor_onehot(input floor_t f);
      return fmask_t'(1) << f;
   endfunction

endpackage

// File: rtl/elevator_call_latch_if.sv
// Request/service link between the call latch (master) and the elevator FSM (slave).
// The FSM reports its floor and door-open pulse; the latch answers with the next target.
interface elevator_call_latch_if;
   import elevator_pkg::*;

   floor_t cur_floor;
   logic   svc_pulse;
   logic   req_valid;
   floor_t req_floor;
   logic   req_dir;

   modport master (input cur_floor, svc_pulse, output req_valid, req_floor, req_dir);
   modport slave  (output cur_floor, svc_pulse, input req_valid, req_floor, req_dir);

endinterface

// File: rtl/elevator_in_sync.sv
// Multi-stage synchroniser plus single-cycle edge detector for WIDTH asynchronous inputs.
// Edge appears STAGES cycles after the input changes; no backpressure, one pulse per transition.
module elevator_in_sync #(
   parameter int   WIDTH  = 4,
   parameter int   STAGES = 2,
   parameter logic IDLE   = 1'b0,
   parameter bit   FALL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]             prev_q, prev_d;
   logic [STAGES:0]              flush_q, flush_d;
   logic [WIDTH-1:0]             lvl;

   // flush_q masks edges until the chain has refilled after reset, so a level
   // already present when reset releases is taken as the new idle state.
   always_comb begin
      sync_d[0] = din;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      lvl     = sync_q[STAGES-1];
      prev_d  = lvl;
      flush_d = flush_q >> 1;
      if (FALL) begin
         edge_pulse = prev_q & ~lvl;
      end else begin
         edge_pulse = ~prev_q & lvl;
      end
      if (|flush_q) begin
         edge_pulse = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= {WIDTH{IDLE}};
         end
         prev_q  <= {WIDTH{IDLE}};
         flush_q <= '1;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         flush_q <= flush_d;
      end
   end

endmodule

// File: rtl/elevator_call_latch.sv
// Latches cabin/hall calls from raw board inputs and picks the next target floor by SCAN.
// Input to pend_* in SYNC_STAGES+1 cycles, req_* one cycle later; no backpressure (level outputs).
module elevator_call_latch
   import elevator_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  CLOCK_50,
   input  logic                  rst,
   input  logic [N_FLOORS-1:0]   cab_key_n,
   input  logic [N_FLOORS-1:0]   hall_sw,
   elevator_call_latch_if.master req_if,
   output logic [N_FLOORS-1:0]   pend_cab,
   output logic [N_FLOORS-1:0]   pend_hall,
   output logic [N_FLOORS-1:0]   pend_any
);

   fmask_t cab_edge, hall_edge;
   fmask_t pend_cab_q, pend_cab_d;
   fmask_t pend_hall_q, pend_hall_d;
   fmask_t pa, clr;
   logic   req_valid_q, req_valid_d;
   floor_t req_floor_q, req_floor_d;
   logic   req_dir_q, req_dir_d;
   logic   any_above, any_below;
   floor_t lo_above, hi_below;

   elevator_in_sync #(.WIDTH(N_FLOORS), .STAGES(SYNC_STAGES), .IDLE(1'b1), .FALL(1'b1)) u_cab_sync (
      .clk        (CLOCK_50),
      .rst        (rst),
      .din        (cab_key_n),
      .edge_pulse (cab_edge)
   );

   elevator_in_sync #(.WIDTH(N_FLOORS), .STAGES(SYNC_STAGES), .IDLE(1'b0), .FALL(1'b0)) u_hall_sync (
      .clk        (CLOCK_50),
      .rst        (rst),
      .din        (hall_sw),
      .edge_pulse (hall_edge)
   );

   always_comb begin
      pa  = pend_cab_q | pend_hall_q;
      clr = req_if.svc_pulse ? floor_onehot(req_if.cur_floor) : '0;

      // An edge arriving with the door opening at that floor is already served.
      pend_cab_d  = (pend_cab_q  | cab_edge)  & ~clr;
      pend_hall_d = (pend_hall_q | hall_edge) & ~clr;

      any_above = 1'b0;
      lo_above  = F1;
      for (int f = N_FLOORS-1; f >= 0; f--) begin
         if (pa[f] && f > int'(req_if.cur_floor)) begin
            any_above = 1'b1;
            lo_above  = floor_t'(f);
         end
      end
      any_below = 1'b0;
      hi_below  = F1;
      for (int f = 0; f < N_FLOORS; f++) begin
         if (pa[f] && f < int'(req_if.cur_floor)) begin
            any_below = 1'b1;
            hi_below  = floor_t'(f);
         end
      end

      req_valid_d = |pa;
      req_floor_d = req_floor_q;
      req_dir_d   = req_dir_q;
      if (|pa) begin
         if (pa[req_if.cur_floor] && !req_if.svc_pulse) begin
            req_floor_d = req_if.cur_floor;
         end else if (req_dir_q == DIR_UP) begin
            if (any_above) begin
               req_floor_d = lo_above;
            end else if (any_below) begin
               req_dir_d   = DIR_DN;
               req_floor_d = hi_below;
            end
         end else begin
            if (any_below) begin
               req_floor_d = hi_below;
            end else if (any_above) begin
               req_dir_d   = DIR_UP;
               req_floor_d = lo_above;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         pend_cab_q  <= '0;
         pend_hall_q <= '0;
         req_valid_q <= 1'b0;
         req_floor_q <= F1;
         req_dir_q   <= DIR_UP;
      end else begin
         pend_cab_q  <= pend_cab_d;
         pend_hall_q <= pend_hall_d;
         req_valid_q <= req_valid_d;
         req_floor_q <= req_floor_d;
         req_dir_q   <= req_dir_d;
      end
   end

   assign pend_cab         = pend_cab_q;
   assign pend_hall        = pend_hall_q;
   assign pend_any         = pend_cab_q | pend_hall_q;
   assign req_if.req_valid = req_valid_q;
   assign req_if.req_floor = req_floor_q;
   assign req_if.req_dir   = req_dir_q;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Directed bench for elevator_call_latch: expected outputs queued at stimulus time, checked on output.
module tb_elevator_call_latch;
   import elevator_pkg::*;

   logic       CLOCK_50 = 1'b0;
   logic       rst;
   logic [3:0] cab_key_n;
   logic [3:0] hall_sw;
   logic [3:0] pend_cab, pend_hall, pend_any;

   elevator_call_latch_if bus ();

   elevator_call_latch dut (
      .CLOCK_50  (CLOCK_50),
      .rst       (rst),
      .cab_key_n (cab_key_n),
      .hall_sw   (hall_sw),
      .req_if    (bus.master),
      .pend_cab  (pend_cab),
      .pend_hall (pend_hall),
      .pend_any  (pend_any)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Expected image: {pend_cab, pend_hall, pend_any, req_valid, req_floor, req_dir}
   task automatic expect_out(input string tag, input logic [3:0] pc, input logic [3:0] ph,
                             input logic v, input logic [1:0] f, input logic d);
      exp_t e;
      e.tag = tag;
      e.v   = {pc, ph, pc | ph, v, f, d};
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t        e;
      logic [15:0] obs;
      e   = sb.pop_front();
      obs = {pend_cab, pend_hall, pend_any, bus.req_valid, bus.req_floor, bus.req_dir};
      total++;
      assert (obs === e.v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
   endtask

   task automatic exp_chk(input string tag, input logic [3:0] pc, input logic [3:0] ph,
                          input logic v, input logic [1:0] f, input logic d);
      expect_out(tag, pc, ph, v, f, d);
      check_out();
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_chk(tag, 4'b0000, 4'b0000, 1'b0, F1, DIR_UP);
      step(3);
   endtask

   task automatic svc_step();
      bus.svc_pulse = 1'b1;
      step(1);
      bus.svc_pulse = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      cab_key_n     = 4'b1111;
      hall_sw       = 4'b0000;
      bus.cur_floor = F1;
      bus.svc_pulse = 1'b0;

      // Held cabin key: exactly one call, latency 3 to pend, 4 to req
      do_reset("reset");
      cab_key_n = 4'b1011;
      step(2);
      exp_chk("cab_lat2", 4'b0000, 4'b0000, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("cab_lat3", 4'b0100, 4'b0000, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("cab_req", 4'b0100, 4'b0000, 1'b1, F3, DIR_UP);
      step(10);
      exp_chk("cab_held", 4'b0100, 4'b0000, 1'b1, F3, DIR_UP);
      bus.cur_floor = F3;
      step(1);
      svc_step();
      exp_chk("cab_svc", 4'b0000, 4'b0000, 1'b1, F3, DIR_UP);
      step(5);
      exp_chk("cab_no_reset", 4'b0000, 4'b0000, 1'b0, F3, DIR_UP);
      cab_key_n = 4'b1111;
      step(4);
      exp_chk("cab_release", 4'b0000, 4'b0000, 1'b0, F3, DIR_UP);

      // Two hall calls at floors 1 and 4 from floor 1
      do_reset("reset2");
      bus.cur_floor = F1;
      hall_sw = 4'b1001;
      step(3);
      exp_chk("hall_lat", 4'b0000, 4'b1001, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("hall_at_floor", 4'b0000, 4'b1001, 1'b1, F1, DIR_UP);
      svc_step();
      exp_chk("hall_after_svc", 4'b0000, 4'b1000, 1'b1, F4, DIR_UP);
      hall_sw = 4'b0000;

      // Upward scan, then reversal when nothing remains above
      do_reset("reset3");
      bus.cur_floor = F2;
      cab_key_n = 4'b1010;
      step(3);
      exp_chk("scan_lat", 4'b0101, 4'b0000, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("scan_up", 4'b0101, 4'b0000, 1'b1, F3, DIR_UP);
      cab_key_n = 4'b1111;
      bus.cur_floor = F3;
      step(1);
      exp_chk("scan_arrive", 4'b0101, 4'b0000, 1'b1, F3, DIR_UP);
      svc_step();
      exp_chk("scan_turn", 4'b0001, 4'b0000, 1'b1, F1, DIR_DN);

      // Cabin edge coincides with service at the same floor
      do_reset("reset4");
      bus.cur_floor = F2;
      hall_sw = 4'b0010;
      step(3);
      exp_chk("conf_hall", 4'b0000, 4'b0010, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("conf_req", 4'b0000, 4'b0010, 1'b1, F2, DIR_UP);
      cab_key_n = 4'b1101;
      step(2);
      svc_step();
      exp_chk("conf_clear", 4'b0000, 4'b0000, 1'b1, F2, DIR_UP);
      step(1);
      exp_chk("conf_drop", 4'b0000, 4'b0000, 1'b0, F2, DIR_UP);
      cab_key_n = 4'b1111;
      hall_sw = 4'b0000;

      // All hall calls, served floor by floor going up
      do_reset("reset5");
      bus.cur_floor = F1;
      hall_sw = 4'b1111;
      step(3);
      exp_chk("all_lat", 4'b0000, 4'b1111, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("all_t0", 4'b0000, 4'b1111, 1'b1, F1, DIR_UP);
      svc_step();
      exp_chk("all_svc0", 4'b0000, 4'b1110, 1'b1, F2, DIR_UP);
      bus.cur_floor = F2;
      step(1);
      exp_chk("all_t1", 4'b0000, 4'b1110, 1'b1, F2, DIR_UP);
      svc_step();
      exp_chk("all_svc1", 4'b0000, 4'b1100, 1'b1, F3, DIR_UP);
      bus.cur_floor = F3;
      step(1);
      exp_chk("all_t2", 4'b0000, 4'b1100, 1'b1, F3, DIR_UP);
      svc_step();
      exp_chk("all_svc2", 4'b0000, 4'b1000, 1'b1, F4, DIR_UP);
      bus.cur_floor = F4;
      step(1);
      exp_chk("all_t3", 4'b0000, 4'b1000, 1'b1, F4, DIR_UP);
      svc_step();
      exp_chk("all_svc3", 4'b0000, 4'b0000, 1'b1, F4, DIR_UP);
      step(1);
      exp_chk("all_idle", 4'b0000, 4'b0000, 1'b0, F4, DIR_UP);
      hall_sw = 4'b0000;

      // Reset mid-operation with inputs held through it
      do_reset("reset6");
      bus.cur_floor = F1;
      cab_key_n = 4'b1101;
      hall_sw = 4'b1000;
      step(3);
      exp_chk("mid_lat", 4'b0010, 4'b1000, 1'b0, F1, DIR_UP);
      step(1);
      exp_chk("mid_req", 4'b0010, 4'b1000, 1'b1, F2, DIR_UP);
      do_reset("mid_reset");
      step(3);
      exp_chk("mid_held", 4'b0000, 4'b0000, 1'b0, F1, DIR_UP);
      cab_key_n = 4'b1111;
      hall_sw = 4'b0000;
      step(4);
      cab_key_n = 4'b1101;
      step(3);
      exp_chk("mid_repress", 4'b0010, 4'b0000, 1'b0, F1, DIR_UP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
